key_autotype_injector: RTL
==========================

// Module: key_autotype_injector
// PURPOSE
//  Sits between the HPS ps2_key bus and the keyboard matrix block. Merges live PS/2 key events
//  with a paced, byte-at-a-time ASCII stream, e.g. paste or autoboot text. Each ASCII byte becomes
//  a timed sequence of press/release events in the ps2_key format (optional shift wrap).
//  The output drives the keyboard block's ps2_key input unchanged.
// PARAMETERS
//  HOLD_CYCLES  400000  clk_sys cycles to wait after each press event (shift or key)
//  GAP_CYCLES   400000  clk_sys cycles to wait after the final release, before accepting the next byte
// PORTS
//  clk_sys      in   1   system clock; all logic on posedge
//  reset        in   1   synchronous, active-high reset
//  ps2_key_in   in   11  live key event from HPS: [7:0] code, [8] ext, [9] pressed, [10] toggle
//  ascii_data   in   8   character to type
//  ascii_valid  in   1   ascii_data valid
//  ascii_ready  out  1   byte accepted on the cycle where valid&ready
//  ps2_key_out  out  11  merged event stream; [10] toggles once per emitted event
//  busy         out  1   high whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset values: ps2_key_out=0, ascii_ready=0 (rises on the cycle after reset deasserts), busy=0, FSM=IDLE.
//  The live toggle tracker loads ps2_key_in[10] during reset, so no live event is generated by reset itself.
//  Reset mid-sequence: return to IDLE and emit no release events. The toggle may drop 1->0;
//  the keyboard sees code 00, which is unmapped and harmless.
//  Live path: when ps2_key_in[10] differs from its registered copy, emit {ps2_key_in[9:0]} on the next cycle.
//  Live events have priority and are never dropped.
//  Emit: ps2_key_out[9:0] <= event and ps2_key_out[10] <= ~ps2_key_out[10]. At most one emit per cycle.
//  Collision: if a live event and an FSM emit fall on the same cycle, the live event is emitted.
//  The FSM holds in its emit state and retries on the next cycle; wait counters start only after its own emit.
//  FSM states: IDLE -> (accept) LOOKUP -> [SHIFT_DN -> WAIT_H] -> KEY_DN -> WAIT_H -> KEY_UP
//   -> [SHIFT_UP] -> WAIT_G -> IDLE. The shift states are taken only when the lookup sets need_shift.
//  After SHIFT_DN, WAIT_H returns to KEY_DN. After KEY_DN, WAIT_H proceeds to KEY_UP.
//  ascii_ready = (state==IDLE). One byte is in flight at a time; no FIFO.
//  LOOKUP takes 1 cycle and registers the {code, need_shift, ok} table output.
//  If !ok, go straight to IDLE with no events and no gap; the byte is silently consumed.
//  Wait counter: 32-bit down-counter loaded with PARAM-1 on entry to a wait state; exit when it reaches 0.
//  A parameter value of 0 is treated as 1.
//  Events: shift = {ext0,press1,8'h12}; release = press0. Injected events always have ext=0.
//  Mapping: 'A'-'Z' and 'a'-'z' -> letter codes (1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A), no shift.
//  More mapping: '0'-'9' -> 45,16,1E,26,25,2E,36,3D,3E,46; ' '->29; 0x0D->5A; 0x08->66; ','->41; '.'->49; '/'->4A;
//  '-'->7B; '*'->7C; '+'->79. '<','>','?' -> same code as ',','.','/' with need_shift=1. All other bytes: ok=0.
//  A live shift press during injection is passed through untouched; no arbitration of matrix state.
// STRUCTURE
//  Shared package kbd_pkg: typedef ps2_evt_t (11-bit packed: tgl, pressed, ext, code),
//   localparam SC_LSHIFT=8'h12, and the FSM state enum.
//  Sub-module ascii_scancode_rom: combinational, ascii[7:0] -> {ok, need_shift, code[7:0]}.
//  The top holds the FSM, wait counter, live edge detector and output arbiter.
// TESTING (bench uses HOLD_CYCLES=4, GAP_CYCLES=6)
//  1) Send 'A' (0x41) -> out 1C press, 4 cycles later 1C release, ready again 6 cycles after the release; toggle flips twice.
//  2) Send '?' (0x3F) -> sequence 12 press, 4A press, 4A release, 12 release; waits of 4,4,0 then gap 6.
//  3) Send 0x7E (unsupported) -> ready back after 2 cycles, no toggle change on ps2_key_out.
//  4) A live event (code 29, press) lands on the KEY_DN emit cycle -> 29 emitted first, 1C one cycle later; no event lost.
//  5) Assert reset between KEY_DN and KEY_UP -> outputs 0, busy 0, no release emitted; the next byte types normally.
//  6) Stream "HI\r" with back-to-back valid -> codes 33,43,5A in order, each as press/release, each ready high only in IDLE.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types for the autotype injector: PS/2 event layout, shift scancode,
// injector FSM states and wait-counter load helper.
package kbd_pkg;

    typedef struct packed {
        logic       tgl;
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

    localparam logic [7:0] SC_LSHIFT = 8'h12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_SHIFT_DN,
        ST_WAIT_H,
        ST_KEY_DN,
        ST_KEY_UP,
        ST_SHIFT_UP,
        ST_WAIT_G
    } inj_state_t;

    // A requested wait of 0 cycles behaves like 1.
    function automatic logic [31:0] wait_load(input int unsigned cycles);
        return (cycles == 0) ? 32'd0 : 32'(cycles - 1);
    endfunction

endpackage

// File: rtl/ascii_scancode_rom.sv
// Combinational ASCII -> PS/2 set-2 scancode table with shift flag.
module ascii_scancode_rom
    import kbd_pkg::*;
(
    input  logic [7:0] ascii_i,
    output logic       ok_o,
    output logic       need_shift_o,
    output logic [7:0] code_o
);

    always_comb begin
        ok_o         = 1'b1;
        need_shift_o = 1'b0;
        code_o       = '0;
        case (ascii_i)
            8'h41, 8'h61: code_o = 8'h1C;
            8'h42, 8'h62: code_o = 8'h32;
            8'h43, 8'h63: code_o = 8'h21;
            8'h44, 8'h64: code_o = 8'h23;
            8'h45, 8'h65: code_o = 8'h24;
            8'h46, 8'h66: code_o = 8'h2B;
            8'h47, 8'h67: code_o = 8'h34;
            8'h48, 8'h68: code_o = 8'h33;
            8'h49, 8'h69: code_o = 8'h43;
            8'h4A, 8'h6A: code_o = 8'h3B;
            8'h4B, 8'h6B: code_o = 8'h42;
            8'h4C, 8'h6C: code_o = 8'h4B;
            8'h4D, 8'h6D: code_o = 8'h3A;
            8'h4E, 8'h6E: code_o = 8'h31;
            8'h4F, 8'h6F: code_o = 8'h44;
            8'h50, 8'h70: code_o = 8'h4D;
            8'h51, 8'h71: code_o = 8'h15;
            8'h52, 8'h72: code_o = 8'h2D;
            8'h53, 8'h73: code_o = 8'h1B;
            8'h54, 8'h74: code_o = 8'h2C;
            8'h55, 8'h75: code_o = 8'h3C;
            8'h56, 8'h76: code_o = 8'h2A;
            8'h57, 8'h77: code_o = 8'h1D;
            8'h58, 8'h78: code_o = 8'h22;
            8'h59, 8'h79: code_o = 8'h35;
            8'h5A, 8'h7A: code_o = 8'h1A;
            8'h30: code_o = 8'h45;
            8'h31: code_o = 8'h16;
            8'h32: code_o = 8'h1E;
            8'h33: code_o = 8'h26;
            8'h34: code_o = 8'h25;
            8'h35: code_o = 8'h2E;
            8'h36: code_o = 8'h36;
            8'h37: code_o = 8'h3D;
            8'h38: code_o = 8'h3E;
            8'h39: code_o = 8'h46;
            8'h20: code_o = 8'h29;
            8'h0D: code_o = 8'h5A;
            8'h08: code_o = 8'h66;
            8'h2C: code_o = 8'h41;
            8'h2E: code_o = 8'h49;
            8'h2F: code_o = 8'h4A;
            8'h2D: code_o = 8'h7B;
            8'h2A: code_o = 8'h7C;
            8'h2B: code_o = 8'h79;
            8'h3C: begin code_o = 8'h41; need_shift_o = 1'b1; end
            8'h3E: begin code_o = 8'h49; need_shift_o = 1'b1; end
            8'h3F: begin code_o = 8'h4A; need_shift_o = 1'b1; end
            default: ok_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/key_autotype_injector.sv
// Merges live PS/2 key events with paced injected ASCII keystrokes into one
// ps2_key stream; live events always win a same-cycle collision.
module key_autotype_injector
    import kbd_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 400000,
    parameter int unsigned GAP_CYCLES  = 400000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key_in,
    input  logic [7:0]  ascii_data,
    input  logic        ascii_valid,
    output logic        ascii_ready,
    output logic [10:0] ps2_key_out,
    output logic        busy
);

    localparam logic [31:0] HOLD_LD = wait_load(HOLD_CYCLES);
    localparam logic [31:0] GAP_LD  = wait_load(GAP_CYCLES);

    inj_state_t  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        after_key_q, after_key_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  code_q, code_d;
    logic        shift_q, shift_d;
    logic        ready_q, ready_d;
    ps2_evt_t    out_q, out_d;
    logic        live_tgl_q;

    logic        rom_ok, rom_shift;
    logic [7:0]  rom_code;
    logic        live_evt, fsm_emit, fsm_press;
    logic [7:0]  fsm_code;

    ascii_scancode_rom u_rom (
        .ascii_i      (byte_q),
        .ok_o         (rom_ok),
        .need_shift_o (rom_shift),
        .code_o       (rom_code)
    );

    assign live_evt = ps2_key_in[10] != live_tgl_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        after_key_d = after_key_q;
        byte_d      = byte_q;
        code_d      = code_q;
        shift_d     = shift_q;
        fsm_emit    = 1'b0;
        fsm_press   = 1'b0;
        fsm_code    = code_q;
        // Emit states advance only when no live event steals this cycle.
        case (state_q)
            ST_IDLE: begin
                if (ascii_valid && ready_q) begin
                    byte_d  = ascii_data;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                code_d  = rom_code;
                shift_d = rom_shift;
                if (!rom_ok)        state_d = ST_IDLE;
                else if (rom_shift) state_d = ST_SHIFT_DN;
                else                state_d = ST_KEY_DN;
            end
            ST_SHIFT_DN: begin
                fsm_emit  = 1'b1;
                fsm_press = 1'b1;
                fsm_code  = SC_LSHIFT;
                if (!live_evt) begin
                    state_d     = ST_WAIT_H;
                    cnt_d       = HOLD_LD;
                    after_key_d = 1'b0;
                end
            end
            ST_KEY_DN: begin
                fsm_emit  = 1'b1;
                fsm_press = 1'b1;
                if (!live_evt) begin
                    state_d     = ST_WAIT_H;
                    cnt_d       = HOLD_LD;
                    after_key_d = 1'b1;
                end
            end
            ST_WAIT_H: begin
                if (cnt_q == '0) state_d = after_key_q ? ST_KEY_UP : ST_KEY_DN;
                else             cnt_d   = cnt_q - 32'd1;
            end
            ST_KEY_UP: begin
                fsm_emit = 1'b1;
                if (!live_evt) begin
                    state_d = shift_q ? ST_SHIFT_UP : ST_WAIT_G;
                    cnt_d   = GAP_LD;
                end
            end
            ST_SHIFT_UP: begin
                fsm_emit = 1'b1;
                fsm_code = SC_LSHIFT;
                if (!live_evt) begin
                    state_d = ST_WAIT_G;
                    cnt_d   = GAP_LD;
                end
            end
            ST_WAIT_G: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 32'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        out_d = out_q;
        if (live_evt)
            out_d = {~out_q.tgl, ps2_key_in[9:0]};
        else if (fsm_emit)
            out_d = '{tgl: ~out_q.tgl, pressed: fsm_press, ext: 1'b0, code: fsm_code};

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_sys) begin
        live_tgl_q <= ps2_key_in[10];
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            after_key_q <= 1'b0;
            byte_q      <= '0;
            code_q      <= '0;
            shift_q     <= 1'b0;
            ready_q     <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            after_key_q <= after_key_d;
            byte_q      <= byte_d;
            code_q      <= code_d;
            shift_q     <= shift_d;
            ready_q     <= ready_d;
            out_q       <= out_d;
        end
    end

    assign ascii_ready = ready_q;
    assign ps2_key_out = out_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
